pre_equ_diag_interp: RTL and testbench

- Parametrised, pipelined successor to the 4-neighbour diagonal R/B pre-equation stage in the CFA demosaic path.
- Estimates the missing R (at B sites) or B (at R sites) from four diagonal neighbours plus their green values and the centre green.
- Selectable mode: bilinear, gradient-corrected, or edge-directed diagonal.
- Adds valid/ready flow control, so it sits between the green-interpolation stage and the R/B writeback buffer.

---
 rtl/pre_equ_diag_interp.sv | 170 +++++++++++++++++
 tb/tb_pre_equ_diag_interp.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pre_equ_diag_interp.sv
// Three-stage diagonal R/B estimator for the CFA demosaic path (bilinear, gradient-corrected,
// edge-directed) with valid/ready flow control. Define PRE_EQU_DIAG_SAT_EN to clamp RB to [0, 2^DATA_W-1].
module pre_equ_diag_interp #(
    parameter int DATA_W = 12,
    localparam int OUT_W = DATA_W + 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               mode,
    input  logic [DATA_W-1:0]        G_c,
    input  logic [DATA_W-1:0]        G_m1_m1,
    input  logic [DATA_W-1:0]        G_m1_p1,
    input  logic [DATA_W-1:0]        G_p1_m1,
    input  logic [DATA_W-1:0]        G_p1_p1,
    input  logic [DATA_W-1:0]        RB_m1_m1,
    input  logic [DATA_W-1:0]        RB_m1_p1,
    input  logic [DATA_W-1:0]        RB_p1_m1,
    input  logic [DATA_W-1:0]        RB_p1_p1,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  RB
);

    function automatic logic [DATA_W-1:0] round_div4(input logic [DATA_W+1:0] s);
        return DATA_W'((s + (DATA_W+2)'(2)) >> 2);
    endfunction

    function automatic logic [DATA_W-1:0] round_div2(input logic [DATA_W:0] s);
        return DATA_W'((s + (DATA_W+1)'(1)) >> 1);
    endfunction

    function automatic logic [DATA_W-1:0] abs_diff(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // |2*gc - a - b| never exceeds 2*(2^DATA_W-1), so DATA_W+1 bits suffice.
    function automatic logic [DATA_W:0] lap_abs(input logic [DATA_W-1:0] gc,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        logic [DATA_W+1:0] two_gc;
        logic [DATA_W+1:0] gs;
        two_gc = {1'b0, gc, 1'b0};
        gs     = {2'b00, a} + {2'b00, b};
        return (DATA_W+1)'((two_gc >= gs) ? (two_gc - gs) : (gs - two_gc));
    endfunction

`ifdef PRE_EQU_DIAG_SAT_EN
    localparam logic signed [OUT_W-1:0] PIX_MAX = $signed({2'b00, {DATA_W{1'b1}}});

    function automatic logic signed [OUT_W-1:0] saturate(input logic signed [OUT_W-1:0] v);
        if (v[OUT_W-1])
            return '0;
        else if (v > PIX_MAX)
            return PIX_MAX;
        else
            return v;
    endfunction
`endif

    logic advance;

    logic              vld_p1;
    logic [DATA_W+1:0] srb_p1, sg_p1;
    logic [DATA_W:0]   prb_a_p1, prb_b_p1, pg_a_p1, pg_b_p1;
    logic [DATA_W-1:0] drb_a_p1, drb_b_p1;
    logic [DATA_W:0]   lap_a_p1, lap_b_p1;
    logic [DATA_W-1:0] gc_p1;
    logic [1:0]        mode_p1;

    logic              vld_p2;
    logic [DATA_W-1:0] base_p2, corr_p2, gc_p2;
    logic              use_corr_p2;

    logic [DATA_W-1:0] base_d, corr_d;
    logic              use_corr_d;
    logic [DATA_W+1:0] d_a, d_b;
    logic signed [OUT_W-1:0] raw_d, rb_d;

    assign advance  = out_ready | ~out_valid;
    assign in_ready = advance;

    // Stage 2 selection: mode 3 falls into the default (bilinear) arm.
    always_comb begin
        d_a        = {2'b00, drb_a_p1} + {1'b0, lap_a_p1};
        d_b        = {2'b00, drb_b_p1} + {1'b0, lap_b_p1};
        base_d     = round_div4(srb_p1);
        corr_d     = round_div4(sg_p1);
        use_corr_d = 1'b0;
        case (mode_p1)
            2'd1: use_corr_d = 1'b1;
            2'd2: begin
                use_corr_d = 1'b1;
                if (d_a < d_b) begin
                    base_d = round_div2(prb_a_p1);
                    corr_d = round_div2(pg_a_p1);
                end else if (d_b < d_a) begin
                    base_d = round_div2(prb_b_p1);
                    corr_d = round_div2(pg_b_p1);
                end
            end
            default: ;
        endcase
    end

    // Stage 3 arithmetic: base + G_c - corrG spans -(2^DATA_W-1)..2*(2^DATA_W-1), fits OUT_W.
    always_comb begin
        if (use_corr_p2)
            raw_d = $signed({2'b00, base_p2}) + $signed({2'b00, gc_p2}) - $signed({2'b00, corr_p2});
        else
            raw_d = $signed({2'b00, base_p2});
`ifdef PRE_EQU_DIAG_SAT_EN
        rb_d = saturate(raw_d);
`else
        rb_d = raw_d;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_p1      <= 1'b0;
            srb_p1      <= '0;
            sg_p1       <= '0;
            prb_a_p1    <= '0;
            prb_b_p1    <= '0;
            pg_a_p1     <= '0;
            pg_b_p1     <= '0;
            drb_a_p1    <= '0;
            drb_b_p1    <= '0;
            lap_a_p1    <= '0;
            lap_b_p1    <= '0;
            gc_p1       <= '0;
            mode_p1     <= '0;
            vld_p2      <= 1'b0;
            base_p2     <= '0;
            corr_p2     <= '0;
            gc_p2       <= '0;
            use_corr_p2 <= 1'b0;
            out_valid   <= 1'b0;
            RB          <= '0;
        end else if (advance) begin
            // Stage 1: sums, pair sums and per-diagonal gradients.
            vld_p1   <= in_valid;
            srb_p1   <= {2'b00, RB_m1_m1} + {2'b00, RB_m1_p1} + {2'b00, RB_p1_m1} + {2'b00, RB_p1_p1};
            sg_p1    <= {2'b00, G_m1_m1} + {2'b00, G_m1_p1} + {2'b00, G_p1_m1} + {2'b00, G_p1_p1};
            prb_a_p1 <= {1'b0, RB_m1_m1} + {1'b0, RB_p1_p1};
            prb_b_p1 <= {1'b0, RB_m1_p1} + {1'b0, RB_p1_m1};
            pg_a_p1  <= {1'b0, G_m1_m1} + {1'b0, G_p1_p1};
            pg_b_p1  <= {1'b0, G_m1_p1} + {1'b0, G_p1_m1};
            drb_a_p1 <= abs_diff(RB_m1_m1, RB_p1_p1);
            drb_b_p1 <= abs_diff(RB_m1_p1, RB_p1_m1);
            lap_a_p1 <= lap_abs(G_c, G_m1_m1, G_p1_p1);
            lap_b_p1 <= lap_abs(G_c, G_m1_p1, G_p1_m1);
            gc_p1    <= G_c;
            mode_p1  <= mode;
            // Stage 2: rounded averages and (base, corrG) selection.
            vld_p2      <= vld_p1;
            base_p2     <= base_d;
            corr_p2     <= corr_d;
            gc_p2       <= gc_p1;
            use_corr_p2 <= use_corr_d;
            // Stage 3: registered output.
            out_valid <= vld_p2;
            RB        <= rb_d;
        end
    end

endmodule

// File: tb/tb_pre_equ_diag_interp.sv
// Scoreboard bench for pre_equ_diag_interp: expected results queued at acceptance, compared in order.
module tb_pre_equ_diag_interp;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  mode;
    logic [11:0] G_c, G_m1_m1, G_m1_p1, G_p1_m1, G_p1_p1;
    logic [11:0] RB_m1_m1, RB_m1_p1, RB_p1_m1, RB_p1_p1;
    logic signed [13:0] RB;

    logic [13:0] exp_q[$];
    logic [13:0] got_q[$];
    logic [13:0] pend_exp;
    int n_checks = 0;
    int n_fail   = 0;

`ifdef PRE_EQU_DIAG_SAT_EN
    localparam logic [13:0] NEG_EXP = 14'd0;
    localparam logic [13:0] OVR_EXP = 14'd4095;
`else
    localparam logic [13:0] NEG_EXP = 14'h3001;
    localparam logic [13:0] OVR_EXP = 14'd8190;
`endif

    always #5 clk = ~clk;

    pre_equ_diag_interp #(.DATA_W(12)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .G_c(G_c), .G_m1_m1(G_m1_m1), .G_m1_p1(G_m1_p1), .G_p1_m1(G_p1_m1), .G_p1_p1(G_p1_p1),
        .RB_m1_m1(RB_m1_m1), .RB_m1_p1(RB_m1_p1), .RB_p1_m1(RB_p1_m1), .RB_p1_p1(RB_p1_p1),
        .out_valid(out_valid), .out_ready(out_ready), .RB(RB)
    );

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // Reference model in plain integer arithmetic; index 0..3 = m1_m1, m1_p1, p1_m1, p1_p1.
    function automatic int model(input int m, input int gc, input int g0, input int g1,
                                 input int g2, input int g3, input int r0, input int r1,
                                 input int r2, input int r3);
        int avg_rb, avg_g, da, db, r;
        avg_rb = (r0 + r1 + r2 + r3 + 2) / 4;
        avg_g  = (g0 + g1 + g2 + g3 + 2) / 4;
        da = iabs(r0 - r3) + iabs(2 * gc - g0 - g3);
        db = iabs(r1 - r2) + iabs(2 * gc - g1 - g2);
        if (m == 1)
            r = avg_rb + gc - avg_g;
        else if (m == 2) begin
            if (da < db)      r = (r0 + r3 + 1) / 2 + gc - (g0 + g3 + 1) / 2;
            else if (db < da) r = (r1 + r2 + 1) / 2 + gc - (g1 + g2 + 1) / 2;
            else              r = avg_rb + gc - avg_g;
        end else
            r = avg_rb;
`ifdef PRE_EQU_DIAG_SAT_EN
        if (r < 0) r = 0;
        if (r > 4095) r = 4095;
`endif
        return r;
    endfunction

    task automatic set_in(input int m, input int gc, input int g0, input int g1, input int g2,
                          input int g3, input int r0, input int r1, input int r2, input int r3,
                          input logic [13:0] e);
        mode = 2'(m); G_c = 12'(gc);
        G_m1_m1 = 12'(g0); G_m1_p1 = 12'(g1); G_p1_m1 = 12'(g2); G_p1_p1 = 12'(g3);
        RB_m1_m1 = 12'(r0); RB_m1_p1 = 12'(r1); RB_p1_m1 = 12'(r2); RB_p1_p1 = 12'(r3);
        pend_exp = e;
        in_valid = 1'b1;
    endtask

    // One clock: observe handshakes just before the rising edge, return at the next falling edge.
    task automatic step(output bit acc);
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) got_q.push_back(RB);
        if (acc) exp_q.push_back(pend_exp);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input int m, input int gc, input int g0, input int g1, input int g2,
                        input int g3, input int r0, input int r1, input int r2, input int r3,
                        input logic [13:0] e);
        bit acc;
        int n;
        set_in(m, gc, g0, g1, g2, g3, r0, r1, r2, r3, e);
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            step(acc);
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_checks++; n_fail++;
            $display("FAIL send_accept: input not accepted within 50 cycles, required acceptance");
        end
    endtask

    task automatic drain();
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && got_q.size() < exp_q.size(); i++) step(acc);
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 14'd0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        n_checks++;
        if (RB !== 14'sd0) begin n_fail++; $display("FAIL reset_rb: got %0d, required 0", RB); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_flat_latency();
        bit acc;
        int lat;
        logic [13:0] e, g;
        out_ready = 1'b1;
        send(1, 1000, 1000, 1000, 1000, 1000, 2000, 2000, 2000, 2000, 14'd2000);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step(acc);
            lat++;
        end
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL flat_latency: got %0d cycles, required 3", lat); end
        drain();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL flat_count: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL flat_value: got %0d, required %0d", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_rounding_and_modes();
        logic [13:0] e, g;
        out_ready = 1'b1;
        send(0, 77, 77, 77, 77, 77, 1, 2, 3, 4, 14'd3);
        send(0, 77, 77, 77, 77, 77, 1, 1, 1, 2, 14'd1);
        send(3, 77, 77, 77, 77, 77, 1, 2, 3, 4, 14'd3);
        send(3, 77, 77, 77, 77, 77, 1, 1, 1, 2, 14'd1);
        send(1, 0, 4095, 4095, 4095, 4095, 0, 0, 0, 0, NEG_EXP);
        send(1, 4095, 0, 0, 0, 0, 4095, 4095, 4095, 4095, OVR_EXP);
        send(2, 500, 500, 500, 500, 500, 100, 4000, 0, 100, 14'd100);
        send(2, 500, 500, 500, 500, 500, 4000, 100, 100, 0, 14'd100);
        send(2, 500, 500, 500, 500, 500, 100, 100, 100, 100, 14'd100);
        // Edge-directed with unequal G: diagonal A wins, correction uses its own green pair.
        send(2, 600, 600, 900, 100, 600, 300, 4000, 0, 310, 14'(model(2, 600, 600, 900, 100, 600, 300, 4000, 0, 310)));
        drain();
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL modes_count: got %0d results, required %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL modes_value[%0d]: got 14'h%h, required 14'h%h", i, g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_pressure();
        bit acc;
        int sent;
        logic [13:0] e, g;
        sent = 0;
        for (int cyc = 0; cyc < 40 && (sent < 6 || got_q.size() < 6); cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            if (sent < 6)
                set_in(0, 0, 0, 0, 0, 0, 100 * (sent + 1), 100 * (sent + 1), 100 * (sent + 1),
                       100 * (sent + 1), 14'(100 * (sent + 1)));
            else
                in_valid = 1'b0;
            #1;
            if (cyc >= 4 && cyc < 9) begin
                n_checks++;
                if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready c%0d: got %b, required 0", cyc, in_ready); end
                n_checks++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid c%0d: got %b, required 1", cyc, out_valid); end
                n_checks++;
                if (RB !== 14'sd200) begin n_fail++; $display("FAIL bp_hold c%0d: got %0d, required 200", cyc, RB); end
            end
            step(acc);
            if (acc) sent++;
        end
        drain();
        n_checks++;
        if (got_q.size() != 6 || exp_q.size() != 6) begin
            n_fail++; $display("FAIL bp_count: got %0d results, required 6", got_q.size());
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL bp_order: got %0d, required %0d", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random_stream();
        bit acc, pend;
        int sent, m, gc, g0, g1, g2, g3, r0, r1, r2, r3;
        logic [13:0] e, g;
        pend = 1'b0;
        sent = 0;
        for (int cyc = 0; cyc < 2000 && sent < 30; cyc++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                m  = $urandom_range(0, 3);
                gc = $urandom_range(0, 4095);
                g0 = $urandom_range(0, 4095); g1 = $urandom_range(0, 4095);
                g2 = $urandom_range(0, 4095); g3 = $urandom_range(0, 4095);
                r0 = $urandom_range(0, 4095); r1 = $urandom_range(0, 4095);
                r2 = $urandom_range(0, 4095); r3 = $urandom_range(0, 4095);
                set_in(m, gc, g0, g1, g2, g3, r0, r1, r2, r3,
                       14'(model(m, gc, g0, g1, g2, g3, r0, r1, r2, r3)));
                pend = 1'b1;
            end
            step(acc);
            if (acc) begin pend = 1'b0; sent++; end
        end
        drain();
        n_checks++;
        if (got_q.size() != 30 || exp_q.size() != 30) begin
            n_fail++; $display("FAIL rand_count: got %0d results, required 30", got_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && got_q.size() > 0; i++) begin
            e = exp_q.pop_front(); g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL rand_value[%0d]: got 14'h%h, required 14'h%h", i, g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_async_reset();
        bit acc;
        int lat;
        logic [13:0] g;
        out_ready = 1'b1;
        send(0, 0, 0, 0, 0, 0, 40, 40, 40, 40, 14'd40);
        send(0, 0, 0, 0, 0, 0, 50, 50, 50, 50, 14'd50);
        send(0, 0, 0, 0, 0, 0, 60, 60, 60, 60, 14'd60);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid: got %b, required 0", out_valid); end
        n_checks++;
        if (RB !== 14'sd0) begin n_fail++; $display("FAIL areset_rb: got %0d, required 0", RB); end
        exp_q.delete(); got_q.delete();
        #1;
        rst = 1'b1;
        @(negedge clk);
        send(1, 300, 200, 200, 200, 200, 1234, 1234, 1234, 1234, 14'd1334);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step(acc);
            lat++;
        end
        n_checks++;
        if (lat !== 3) begin n_fail++; $display("FAIL areset_latency: got %0d cycles, required 3", lat); end
        drain();
        n_checks++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            n_fail++; $display("FAIL areset_count: got %0d results, required 1", got_q.size());
        end else begin
            g = got_q.pop_front();
            n_checks++;
            if (g !== 14'd1334) begin n_fail++; $display("FAIL areset_value: got %0d, required 1334", g); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_flat_latency();
        test_rounding_and_modes();
        test_back_pressure();
        test_random_stream();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
